// File: rtl/pr_status_monitor.sv
// PR status monitor: deglitches the PR IP status bus, maps it to the
// software status encoding, and tracks each operation with a watchdog.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   ip_status[2:0]  PR IP hardware status
//   crc_err         PR IP CRC-error flag
//   incompat_err    PR IP incompatible-bitstream flag
//   sw_clear        CSR pulse; clears stickies and counters
//   sw_status[2:0]  software status code
//   pr_done         one-cycle pulse on successful completion
//   pr_error        one-cycle pulse on errored completion
//   err_sticky      sticky: an operation ended in error
//   timeout_sticky  sticky: watchdog expired
//   illegal_sticky  sticky: an illegal status was accepted
//   ok_count        saturating success counter
//   err_count       saturating error counter
module pr_status_monitor #(
    parameter int STABLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ip_status,
    input  logic             crc_err,
    input  logic             incompat_err,
    input  logic             sw_clear,
    output logic [2:0]       sw_status,
    output logic             pr_done,
    output logic             pr_error,
    output logic             err_sticky,
    output logic             timeout_sticky,
    output logic             illegal_sticky,
    output logic [CNT_W-1:0] ok_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, ACTIVE, TIMEOUT} state_t;

    localparam int              TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      STABLE = 4'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] C_MAX = '1;
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    localparam logic [2:0] IP_NRESET = 3'b000;
    localparam logic [2:0] IP_BUSY   = 3'b001;
    localparam logic [2:0] IP_PROG   = 3'b010;
    localparam logic [2:0] IP_OK     = 3'b011;
    localparam logic [2:0] IP_ERR    = 3'b100;

    logic [2:0]    s0;
    logic [3:0]    cnt;
    logic [2:0]    flt;
    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;

    logic       accept;
    logic       done_ev, err_ev, to_ev, ill_ev;
    logic [2:0] cls_code;
    logic [2:0] sw_nx;

    // cnt = number of edges s0 has held its current value (saturating).
    // The new value is accepted on the edge after it has held long enough,
    // which gives STABLE_CYCLES+1 edges from input change to sw_status.
    assign accept = (cnt >= STABLE) && (s0 != flt);

    always_comb begin
        cls_code = 3'b001;
        if (crc_err)
            cls_code = 3'b010;
        else if (incompat_err)
            cls_code = 3'b011;
    end

    always_comb begin
        sw_nx  = sw_status;
        ill_ev = 1'b0;
        unique case (s0)
            IP_NRESET: sw_nx = 3'b000;
            IP_BUSY:   sw_nx = 3'b110;
            IP_PROG:   sw_nx = 3'b100;
            IP_OK:     sw_nx = 3'b101;
            IP_ERR:    sw_nx = cls_code;
            default:   ill_ev = accept;
        endcase
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        done_ev  = 1'b0;
        err_ev   = 1'b0;
        to_ev    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && s0 == IP_PROG) begin
                    state_nx = ACTIVE;
                    timer_nx = '0;
                end
            end
            ACTIVE: begin
                timer_nx = timer + 1'b1;
                if (accept && s0 == IP_OK) begin
                    done_ev  = 1'b1;
                    state_nx = IDLE;
                end else if (accept && s0 == IP_ERR) begin
                    err_ev   = 1'b1;
                    state_nx = IDLE;
                end else if (accept && s0 == IP_NRESET) begin
                    state_nx = IDLE;
                end else if (timer == T_LAST) begin
                    to_ev    = 1'b1;
                    state_nx = TIMEOUT;
                end
            end
            TIMEOUT: begin
                if (accept && s0 == IP_OK) begin
                    done_ev  = 1'b1;
                    state_nx = IDLE;
                end else if (accept && s0 == IP_ERR) begin
                    err_ev   = 1'b1;
                    state_nx = IDLE;
                end else if (sw_clear ||
                             (accept && s0 == IP_NRESET)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0             <= '0;
            cnt            <= '0;
            flt            <= '0;
            state          <= IDLE;
            timer          <= '0;
            sw_status      <= '0;
            pr_done        <= 1'b0;
            pr_error       <= 1'b0;
            err_sticky     <= 1'b0;
            timeout_sticky <= 1'b0;
            illegal_sticky <= 1'b0;
            ok_count       <= '0;
            err_count      <= '0;
        end else begin
            s0 <= ip_status;
            if (ip_status != s0)
                cnt <= 4'd1;
            else if (cnt != 4'd15)
                cnt <= cnt + 4'd1;

            if (accept) begin
                flt       <= s0;
                sw_status <= sw_nx;
            end

            state    <= state_nx;
            timer    <= timer_nx;
            pr_done  <= done_ev;
            pr_error <= err_ev;

            // An event in the same cycle as sw_clear wins.
            err_sticky     <= err_ev | (err_sticky & ~sw_clear);
            timeout_sticky <= to_ev  | (timeout_sticky & ~sw_clear);
            illegal_sticky <= ill_ev | (illegal_sticky & ~sw_clear);

            if (done_ev)
                ok_count <= sw_clear ? C_ONE :
                            (ok_count == C_MAX) ? ok_count : ok_count + 1'b1;
            else if (sw_clear)
                ok_count <= '0;

            if (err_ev)
                err_count <= sw_clear ? C_ONE :
                             (err_count == C_MAX) ? err_count : err_count + 1'b1;
            else if (sw_clear)
                err_count <= '0;
        end
    end

endmodule

// File: tb/tb_pr_status_monitor.sv
// Directed bench for pr_status_monitor with a queue of expected values.
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_pr_status_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ip_status;
    logic       crc_err;
    logic       incompat_err;
    logic       sw_clear;
    logic [2:0] sw_status;
    logic       pr_done;
    logic       pr_error;
    logic       err_sticky;
    logic       timeout_sticky;
    logic       illegal_sticky;
    logic [3:0] ok_count;
    logic [3:0] err_count;

    int total = 0;
    int bad   = 0;
    int n_done = 0;
    int n_err  = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];

    pr_status_monitor #(
        .STABLE_CYCLES (2),
        .TIMEOUT_CYCLES(16),
        .CNT_W         (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ip_status     (ip_status),
        .crc_err       (crc_err),
        .incompat_err  (incompat_err),
        .sw_clear      (sw_clear),
        .sw_status     (sw_status),
        .pr_done       (pr_done),
        .pr_error      (pr_error),
        .err_sticky    (err_sticky),
        .timeout_sticky(timeout_sticky),
        .illegal_sticky(illegal_sticky),
        .ok_count      (ok_count),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (pr_done === 1'b1) n_done++;
        if (pr_error === 1'b1) n_err++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_v(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val)
            else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d",
                       e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        ip_status    = 3'b000;
        crc_err      = 1'b0;
        incompat_err = 1'b0;
        sw_clear     = 1'b0;
        tick(2);
        rst_n = 1'b1;

        // reset state
        expect_v("rst_sw", 0);
        expect_v("rst_ok", 0);
        expect_v("rst_err", 0);
        expect_v("rst_sticky", 0);
        expect_v("rst_pulses", 0);
        check(32'(sw_status));
        check(32'(ok_count));
        check(32'(err_count));
        check(32'({err_sticky, timeout_sticky, illegal_sticky}));
        check(32'(n_done + n_err));

        // 1: normal flow with exact latency
        ip_status = 3'b001;
        expect_v("busy_early", 0);
        expect_v("busy", 3'b110);
        tick(2); check(32'(sw_status));
        tick(1); check(32'(sw_status));
        tick(2);
        ip_status = 3'b010;
        expect_v("prog_early", 3'b110);
        expect_v("prog", 3'b100);
        tick(2); check(32'(sw_status));
        tick(1); check(32'(sw_status));
        tick(2);
        ip_status = 3'b011;
        expect_v("ok_early", 3'b100);
        expect_v("ok_sw", 3'b101);
        expect_v("ok_done", 1);
        expect_v("ok_cnt", 1);
        tick(2); check(32'(sw_status));
        tick(1); check(32'(sw_status));
        check(32'(n_done));
        check(32'(ok_count));
        tick(2);

        // 2: error classification
        ip_status = 3'b010; tick(3);
        crc_err = 1'b1; incompat_err = 1'b1; ip_status = 3'b100;
        expect_v("crc_sw", 3'b010);
        expect_v("crc_pulse", 1);
        expect_v("crc_sticky", 1);
        expect_v("crc_cnt", 1);
        tick(3);
        check(32'(sw_status));
        check(32'(n_err));
        check(32'(err_sticky));
        check(32'(err_count));
        crc_err = 1'b0; incompat_err = 1'b0;
        ip_status = 3'b010; tick(3);
        incompat_err = 1'b1; ip_status = 3'b100;
        expect_v("inc_sw", 3'b011);
        expect_v("inc_cnt", 2);
        tick(3);
        check(32'(sw_status));
        check(32'(err_count));
        incompat_err = 1'b0;
        ip_status = 3'b010; tick(3);
        ip_status = 3'b100;
        expect_v("gen_sw", 3'b001);
        expect_v("gen_cnt", 3);
        expect_v("gen_pulse", 3);
        tick(3);
        check(32'(sw_status));
        check(32'(err_count));
        check(32'(n_err));

        // 3: watchdog
        ip_status = 3'b010; tick(3);
        expect_v("to_early", 0);
        expect_v("to_set", 1);
        tick(15); check(32'(timeout_sticky));
        tick(1);  check(32'(timeout_sticky));
        ip_status = 3'b011;
        expect_v("late_done", 2);
        expect_v("late_ok", 2);
        expect_v("late_to", 1);
        tick(3);
        check(32'(n_done));
        check(32'(ok_count));
        check(32'(timeout_sticky));
        sw_clear = 1'b1; tick(1); sw_clear = 1'b0;
        expect_v("clr_sticky", 0);
        expect_v("clr_ok", 0);
        expect_v("clr_err", 0);
        expect_v("clr_sw", 3'b101);
        check(32'({err_sticky, timeout_sticky, illegal_sticky}));
        check(32'(ok_count));
        check(32'(err_count));
        check(32'(sw_status));

        // 4: glitch rejection and illegal status
        ip_status = 3'b010; tick(3);
        ip_status = 3'b100; tick(1);
        ip_status = 3'b010; tick(4);
        expect_v("gl_sw", 3'b100);
        expect_v("gl_pulse", 3);
        expect_v("gl_cnt", 0);
        check(32'(sw_status));
        check(32'(n_err));
        check(32'(err_count));
        ip_status = 3'b110; tick(3);
        expect_v("ill_sticky", 1);
        expect_v("ill_sw", 3'b100);
        check(32'(illegal_sticky));
        check(32'(sw_status));
        ip_status = 3'b011; tick(3);
        sw_clear = 1'b1; tick(1); sw_clear = 1'b0;
        expect_v("ill_clr", 0);
        expect_v("ok_clr", 0);
        check(32'(illegal_sticky));
        check(32'(ok_count));

        // 5: counter saturation and clear-vs-event
        for (int i = 0; i < 17; i++) begin
            ip_status = 3'b010; tick(3);
            ip_status = 3'b011; tick(3);
            if (i == 14) begin
                expect_v("sat_15", 15);
                check(32'(ok_count));
            end
        end
        expect_v("sat_17", 15);
        check(32'(ok_count));
        ip_status = 3'b010; tick(3);
        ip_status = 3'b011; tick(2);
        sw_clear = 1'b1; tick(1); sw_clear = 1'b0;
        expect_v("clr_win", 1);
        expect_v("clr_done", 21);
        check(32'(ok_count));
        check(32'(n_done));

        // 6: reset mid-operation, then completion seen from IDLE
        ip_status = 3'b010; tick(3);
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        ip_status = 3'b011;
        expect_v("mid_sw", 0);
        expect_v("mid_ok", 0);
        check(32'(sw_status));
        check(32'(ok_count));
        tick(3);
        expect_v("idle_sw", 3'b101);
        expect_v("idle_done", 21);
        expect_v("idle_err", 3);
        expect_v("idle_ok", 0);
        check(32'(sw_status));
        check(32'(n_done));
        check(32'(n_err));
        check(32'(ok_count));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
